// File: rtl/bram_to_decimal_pkg.sv
// ============================================================================
// Module  : bram_to_decimal_pkg
// Brief   : Shared types, constants and sizing helper for the BRAM-to-BCD reader.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_to_decimal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_CONVERT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef logic [3:0] bcd_nibble_t;

    localparam bcd_nibble_t ADD3_THRESHOLD = 4'd5;
    localparam bcd_nibble_t ADD3_VALUE     = 4'd3;

    // Smallest digit count whose decimal range covers every DATA_WIDTH-bit value.
    function automatic int min_bcd_digits(input int data_width);
        longint unsigned limit;
        longint unsigned pow10;
        int              digits;
        limit  = 64'd1 << data_width;
        pow10  = 64'd1;
        digits = 0;
        while (pow10 < limit) begin
            pow10  = pow10 * 64'd10;
            digits = digits + 1;
        end
        return digits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_to_decimal_reader_dabble.sv
// ============================================================================
// Module  : bcd_dabble_step
// Brief   : One combinational double-dabble iteration (add-3 per nibble, then shift).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble_step
    import bram_to_decimal_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DIGITS     = 4
) (
    input  logic [4*DIGITS-1:0]   bcd_i,
    input  logic [DATA_WIDTH-1:0] bin_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DATA_WIDTH-1:0] bin_o
);

    logic [4*DIGITS-1:0] adj;

    // Each nibble is corrected independently; no carry crosses nibble boundaries.
    for (genvar g = 0; g < DIGITS; g++) begin : g_nibble
        bcd_nibble_t nib;
        assign nib              = bcd_i[4*g +: 4];
        assign adj[4*g +: 4]    = (nib >= ADD3_THRESHOLD) ? (nib + ADD3_VALUE) : nib;
    end

    assign bcd_o = {adj[4*DIGITS-2:0], bin_i[DATA_WIDTH-1]};
    assign bin_o = {bin_i[DATA_WIDTH-2:0], 1'b0};

endmodule

`default_nettype wire

// File: rtl/bram_to_decimal_reader.sv
// ============================================================================
// Module  : bram_to_decimal_reader
// Brief   : Fetches one BRAM word and converts it to packed BCD; optional
//           leading-zero blank mask when BRAM_TO_DECIMAL_BLANK_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_to_decimal_reader
    import bram_to_decimal_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 12,
    parameter int DIGITS     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
`ifdef BRAM_TO_DECIMAL_BLANK_EN
    ,
    output logic [DIGITS-1:0]     digit_blank
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    if (DIGITS < min_bcd_digits(DATA_WIDTH)) begin : g_digits_check
        $error("DIGITS is too small to hold every DATA_WIDTH-bit value");
    end

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  out_valid_q;
    logic [4*DIGITS-1:0]   bcd_out_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [DATA_WIDTH-1:0] bin_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [4*DIGITS-1:0]   bcd_d;
    logic [DATA_WIDTH-1:0] bin_d;

    bcd_dabble_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIGITS     (DIGITS)
    ) u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (bcd_d),
        .bin_o (bin_d)
    );

`ifdef BRAM_TO_DECIMAL_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RESET = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] digit_blank_q;

    // A digit blanks only if it and every more-significant digit are zero.
    always_comb begin
        blank_d           = '0;
        blank_d[DIGITS-1] = (bcd_d[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 1; i--) begin
            blank_d[i] = blank_d[i+1] && (bcd_d[4*i +: 4] == 4'd0);
        end
        blank_d[0] = 1'b0;
    end

    assign digit_blank = digit_blank_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            bcd_out_q   <= '0;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
`ifdef BRAM_TO_DECIMAL_BLANK_EN
            digit_blank_q <= BLANK_RESET;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        mem_addr_q <= req_addr;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    bin_q   <= mem_data;
                    bcd_q   <= '0;
                    cnt_q   <= CNT_W'(DATA_WIDTH);
                    state_q <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_out_q   <= bcd_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
`ifdef BRAM_TO_DECIMAL_BLANK_EN
                        digit_blank_q <= blank_d;
`endif
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here deliberately ignores req_valid for this edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_out_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_to_decimal_reader.sv
// ============================================================================
// Module  : tb_bram_to_decimal_reader
// Brief   : Directed and randomized checks of the BRAM-to-BCD reader against a
//           decimal-arithmetic reference; covers BRAM_TO_DECIMAL_BLANK_EN builds.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_to_decimal_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_addr;
    logic        req_ready;
    logic [3:0]  mem_addr;
    logic [11:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd_out;
    logic        busy;
`ifdef BRAM_TO_DECIMAL_BLANK_EN
    logic [3:0]  digit_blank;
`endif

    int checks   = 0;
    int failures = 0;

    logic [11:0] mem [16];
    logic [3:0]  bram_addr_q = 4'd0;

    always #5 clk = ~clk;

    // Synchronous-read memory: address registered, data read from the registered address.
    always @(posedge clk) bram_addr_q <= mem_addr;
    assign mem_data = mem[bram_addr_q];

    bram_to_decimal_reader #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (12),
        .DIGITS     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bcd_out     (bcd_out),
        .busy        (busy)
`ifdef BRAM_TO_DECIMAL_BLANK_EN
        ,
        .digit_blank (digit_blank)
`endif
    );

    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0]  r;
        int unsigned  div;
        r   = '0;
        div = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / div) % 10);
            div = div * 10;
        end
        return r;
    endfunction

    // Digit i is blank exactly when the value is below 10^i (digit 0 never blank).
    function automatic logic [3:0] ref_blank(input int unsigned v);
        logic [3:0]  m;
        int unsigned p;
        m = 4'b0000;
        p = 10;
        for (int i = 1; i < 4; i++) begin
            m[i] = (v < p);
            p    = p * 10;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_blank(input string tag, input logic [3:0] exp);
`ifdef BRAM_TO_DECIMAL_BLANK_EN
        check(tag, {28'd0, digit_blank}, {28'd0, exp});
`endif
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_conv(input logic [3:0] addr, input int hold, input bit interfere);
        int          n;
        logic [15:0] exp;
        logic [3:0]  expb;
        exp       = ref_bcd(mem[addr]);
        expb      = ref_blank(mem[addr]);
        out_ready = (hold == 0);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        check("accept_mem_addr", {28'd0, mem_addr}, {28'd0, addr});
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_req_ready", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            if (interfere && n == 6) begin
                req_valid = 1'b1;
                req_addr  = 4'd5;
            end
            tick();
            n++;
            req_valid = 1'b0;
            if (interfere && n == 7)
                check("ignored_req_mem_addr", {28'd0, mem_addr}, {28'd0, addr});
        end
        check("latency", n, 14);
        check("bcd_out", {16'd0, bcd_out}, {16'd0, exp});
        check_blank("digit_blank", expb);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_bcd", {16'd0, bcd_out}, {16'd0, exp});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_req_ready", {31'd0, req_ready}, 32'd1);
        check("bcd_kept", {16'd0, bcd_out}, {16'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  saw_valid;

        for (int i = 0; i < 16; i++) mem[i] = 12'($urandom_range(0, 4095));
        mem[0] = 12'd0;
        mem[1] = 12'd7;
        mem[2] = 12'd1000;
        mem[3] = 12'd4095;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 4'd0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bcd_out", {16'd0, bcd_out}, 32'd0);
        check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check_blank("rst_digit_blank", 4'b1110);

        // Directed boundaries: max value (with stray request), zero, small, power of ten.
        run_conv(4'd3, 0, 1'b1);
        run_conv(4'd0, 0, 1'b0);
        run_conv(4'd1, 0, 1'b0);
        run_conv(4'd2, 10, 1'b0);

        // Reset in the middle of a conversion.
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 4'd3;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_bcd_out", {16'd0, bcd_out}, 32'd0);
        check("midrst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check_blank("midrst_digit_blank", 4'b1110);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_valid", {31'd0, saw_valid}, 32'd0);

        // Back-to-back with req_valid held through the DONE handshake.
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 4'd1;
        tick();
        check("b2b_first_addr", {28'd0, mem_addr}, 32'd1);
        wait_valid(n);
        check("b2b_first_latency", n, 14);
        check("b2b_first_bcd", {16'd0, bcd_out}, {16'd0, ref_bcd(mem[1])});
        req_addr = 4'd2;
        tick();
        check("b2b_handshake_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_handshake_idle", {31'd0, req_ready}, 32'd1);
        check("b2b_handshake_addr", {28'd0, mem_addr}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b_second_addr", {28'd0, mem_addr}, 32'd2);
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        wait_valid(n);
        check("b2b_second_latency", n, 14);
        check("b2b_second_bcd", {16'd0, bcd_out}, {16'd0, ref_bcd(mem[2])});
        check_blank("b2b_second_blank", ref_blank(mem[2]));
        tick();
        check("b2b_second_release", {31'd0, out_valid}, 32'd0);

        // Randomized contents, addresses and consumer stalls.
        for (int k = 0; k < 10; k++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            mem[a] = 12'($urandom_range(0, 4095));
            run_conv(a, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
